// File: rtl/midi_pkg.sv
// Shared MIDI constants, parser state encoding and message-length helper
// for the channel-voice message assembler.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHAN_AT  = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;

  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] SYSEX_END   = 8'hF7;
  localparam logic [7:0] RT_MIN      = 8'hF8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_D1 = 2'd1,
    ST_WAIT_D2 = 2'd2,
    ST_SYSEX   = 2'd3
  } state_t;

  // Program change and channel aftertouch carry one data byte; the rest carry two.
  function automatic logic [1:0] data_len(input logic [7:0] status);
    logic [1:0] len;
    case (status[7:4])
      PROG, CHAN_AT: len = 2'd1;
      default:       len = 2'd2;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/midi_msg_assembler.sv
// Rebuilds MIDI channel-voice messages from a raw byte stream, honouring
// running status and skipping SysEx, System Common and Real-Time bytes.
module midi_msg_assembler
  import midi_pkg::*;
#(
  parameter bit         OMNI    = 1'b1,
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [23:0] MIDI_data_out,
  output logic        msg_valid,
  output logic        sync_err
);

  state_t      r_state;
  logic [7:0]  r_running_status;
  logic [7:0]  r_data1;
  logic        r_pending;
  logic [23:0] r_data_out;
  logic        r_msg_valid;
  logic        r_sync_err;

  logic w_is_rt;
  logic w_is_voice;
  logic w_is_system;
  logic w_is_data;
  logic w_rs_valid;
  logic w_chan_ok;

  always_comb begin
    w_is_rt     = byte_in >= RT_MIN;
    w_is_voice  = byte_in[7] && (byte_in < SYSEX_START);
    w_is_system = (byte_in >= SYSEX_START) && !w_is_rt;
    w_is_data   = !byte_in[7];
    w_rs_valid  = r_running_status[7];
    w_chan_ok   = OMNI || (r_running_status[3:0] == CHANNEL);
  end

  // r_pending marks a freshly latched status whose message has not yet
  // completed; replacing it with another voice status abandons that message.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_running_status <= 8'h00;
      r_data1          <= 8'h00;
      r_pending        <= 1'b0;
      r_data_out       <= 24'h000000;
      r_msg_valid      <= 1'b0;
      r_sync_err       <= 1'b0;
    end else begin
      r_msg_valid <= 1'b0;
      r_sync_err  <= 1'b0;
      if (byte_valid && w_is_voice) begin
        if (r_state == ST_WAIT_D2 || (r_state == ST_WAIT_D1 && r_pending))
          r_sync_err <= 1'b1;
        r_running_status <= byte_in;
        r_pending        <= 1'b1;
        r_state          <= ST_WAIT_D1;
      end else if (byte_valid && w_is_system) begin
        r_running_status <= 8'h00;
        r_pending        <= 1'b0;
        r_state          <= (byte_in == SYSEX_START) ? ST_SYSEX : ST_IDLE;
      end else if (byte_valid && w_is_data) begin
        case (r_state)
          ST_IDLE, ST_WAIT_D1: begin
            if (!w_rs_valid) begin
              r_sync_err <= 1'b1;
            end else if (data_len(r_running_status) == 2'd1) begin
              if (w_chan_ok) begin
                r_data_out  <= {r_running_status, byte_in, 8'h00};
                r_msg_valid <= 1'b1;
              end
              r_pending <= 1'b0;
              r_state   <= ST_WAIT_D1;
            end else begin
              r_data1 <= byte_in;
              r_state <= ST_WAIT_D2;
            end
          end
          ST_WAIT_D2: begin
            if (w_chan_ok) begin
              r_data_out  <= {r_running_status, r_data1, byte_in};
              r_msg_valid <= 1'b1;
            end
            r_pending <= 1'b0;
            r_state   <= ST_WAIT_D1;
          end
          default: ;
        endcase
      end
    end
  end

  assign MIDI_data_out = r_data_out;
  assign msg_valid     = r_msg_valid;
  assign sync_err      = r_sync_err;

endmodule

// File: tb/tb_midi_msg_assembler.sv
// Self-checking bench: an omni instance driven from a byte/expectation table
// and a channel-2-only instance driven by hand-written sequences.
module tb_midi_msg_assembler;

  logic        clk;
  logic        rst_a, rst_b;
  logic [7:0]  byte_a, byte_b;
  logic        bv_a, bv_b;
  logic [23:0] data_a, data_b;
  logic        mv_a, mv_b;
  logic        se_a, se_b;

  int checks = 0;
  int errors = 0;

  logic [23:0] q_a[$];
  logic [23:0] q_b[$];

  typedef struct {
    logic [7:0]  b;
    logic        ev;
    logic        ee;
    logic [23:0] ed;
  } vec_t;

  vec_t vecs[$];

  midi_msg_assembler #(.OMNI(1'b1), .CHANNEL(4'd0)) u_omni (
    .clk(clk), .reset(rst_a), .byte_in(byte_a), .byte_valid(bv_a),
    .MIDI_data_out(data_a), .msg_valid(mv_a), .sync_err(se_a)
  );

  midi_msg_assembler #(.OMNI(1'b0), .CHANNEL(4'd2)) u_ch2 (
    .clk(clk), .reset(rst_b), .byte_in(byte_b), .byte_valid(bv_b),
    .MIDI_data_out(data_b), .msg_valid(mv_b), .sync_err(se_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: every msg_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst_a && mv_a) begin
      if (q_a.size() == 0) check("omni_unexpected_msg", {8'h0, data_a}, 32'hFFFFFFFF);
      else check("omni_scoreboard", {8'h0, data_a}, {8'h0, q_a.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (!rst_b && mv_b) begin
      if (q_b.size() == 0) check("ch2_unexpected_msg", {8'h0, data_b}, 32'hFFFFFFFF);
      else check("ch2_scoreboard", {8'h0, data_b}, {8'h0, q_b.pop_front()});
    end
  end

  // Drives one byte for one cycle (called at a negedge) and checks the
  // registered outputs on the following negedge.
  task automatic send(input int which, input logic [7:0] b, input logic ev,
                      input logic ee, input logic [23:0] ed);
    if (which == 0) begin
      if (ev) q_a.push_back(ed);
      byte_a = b; bv_a = 1'b1;
    end else begin
      if (ev) q_b.push_back(ed);
      byte_b = b; bv_b = 1'b1;
    end
    @(negedge clk);
    bv_a = 1'b0; bv_b = 1'b0;
    if (which == 0) begin
      check($sformatf("omni_valid_%02h", b), {31'h0, mv_a}, {31'h0, ev});
      check($sformatf("omni_err_%02h", b), {31'h0, se_a}, {31'h0, ee});
      check($sformatf("omni_data_%02h", b), {8'h0, data_a}, {8'h0, ed});
      $display("omni byte=%02h valid=%0b err=%0b data=%06h", b, mv_a, se_a, data_a);
    end else begin
      check($sformatf("ch2_valid_%02h", b), {31'h0, mv_b}, {31'h0, ev});
      check($sformatf("ch2_err_%02h", b), {31'h0, se_b}, {31'h0, ee});
      check($sformatf("ch2_data_%02h", b), {8'h0, data_b}, {8'h0, ed});
      $display("ch2  byte=%02h valid=%0b err=%0b data=%06h", b, mv_b, se_b, data_b);
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    byte_a = 8'h00; byte_b = 8'h00; bv_a = 1'b0; bv_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    check("reset_data_a", {8'h0, data_a}, 32'h0);
    check("reset_valid_a", {31'h0, mv_a}, 32'h0);
    check("reset_err_a", {31'h0, se_a}, 32'h0);
    check("reset_data_b", {8'h0, data_b}, 32'h0);

    // byte, msg_valid, sync_err, MIDI_data_out (held between messages)
    vecs.push_back('{8'h90, 1'b0, 1'b0, 24'h000000});
    vecs.push_back('{8'h3C, 1'b0, 1'b0, 24'h000000});
    vecs.push_back('{8'h64, 1'b1, 1'b0, 24'h903C64});
    vecs.push_back('{8'h40, 1'b0, 1'b0, 24'h903C64});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 24'h904000});
    vecs.push_back('{8'hC5, 1'b0, 1'b0, 24'h904000});
    vecs.push_back('{8'h07, 1'b1, 1'b0, 24'hC50700});
    vecs.push_back('{8'h08, 1'b1, 1'b0, 24'hC50800});
    vecs.push_back('{8'h80, 1'b0, 1'b0, 24'hC50800});
    vecs.push_back('{8'hF8, 1'b0, 1'b0, 24'hC50800});
    vecs.push_back('{8'h3C, 1'b0, 1'b0, 24'hC50800});
    vecs.push_back('{8'hFE, 1'b0, 1'b0, 24'hC50800});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 24'h803C00});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 24'h803C00});
    vecs.push_back('{8'h7E, 1'b0, 1'b0, 24'h803C00});
    vecs.push_back('{8'h01, 1'b0, 1'b0, 24'h803C00});
    vecs.push_back('{8'hF7, 1'b0, 1'b0, 24'h803C00});
    vecs.push_back('{8'h22, 1'b0, 1'b1, 24'h803C00});
    // abandoned 2-byte message
    vecs.push_back('{8'h90, 1'b0, 1'b0, 24'h803C00});
    vecs.push_back('{8'h3C, 1'b0, 1'b0, 24'h803C00});
    vecs.push_back('{8'hB0, 1'b0, 1'b1, 24'h803C00});
    vecs.push_back('{8'h07, 1'b0, 1'b0, 24'h803C00});
    vecs.push_back('{8'h7F, 1'b1, 1'b0, 24'hB0077F});
    // new status after a completed message is not an error
    vecs.push_back('{8'hE0, 1'b0, 1'b0, 24'hB0077F});
    vecs.push_back('{8'h01, 1'b0, 1'b0, 24'hB0077F});
    vecs.push_back('{8'h40, 1'b1, 1'b0, 24'hE00140});
    // status replaced before any data byte
    vecs.push_back('{8'hD3, 1'b0, 1'b0, 24'hE00140});
    vecs.push_back('{8'hA0, 1'b0, 1'b1, 24'hE00140});
    vecs.push_back('{8'h11, 1'b0, 1'b0, 24'hE00140});
    vecs.push_back('{8'h22, 1'b1, 1'b0, 24'hA01122});
    // system common mid-message clears running status
    vecs.push_back('{8'h90, 1'b0, 1'b0, 24'hA01122});
    vecs.push_back('{8'h10, 1'b0, 1'b0, 24'hA01122});
    vecs.push_back('{8'hF6, 1'b0, 1'b0, 24'hA01122});
    vecs.push_back('{8'h10, 1'b0, 1'b1, 24'hA01122});
    // voice status exits SysEx directly
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 24'hA01122});
    vecs.push_back('{8'h12, 1'b0, 1'b0, 24'hA01122});
    vecs.push_back('{8'h93, 1'b0, 1'b0, 24'hA01122});
    vecs.push_back('{8'h45, 1'b0, 1'b0, 24'hA01122});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 24'h934500});

    foreach (vecs[i]) send(0, vecs[i].b, vecs[i].ev, vecs[i].ee, vecs[i].ed);

    // Channel filter: channel 1 parsed but suppressed, channel 2 emitted.
    send(1, 8'h91, 1'b0, 1'b0, 24'h000000);
    send(1, 8'h3C, 1'b0, 1'b0, 24'h000000);
    send(1, 8'h64, 1'b0, 1'b0, 24'h000000);
    send(1, 8'h92, 1'b0, 1'b0, 24'h000000);
    send(1, 8'h3C, 1'b0, 1'b0, 24'h000000);
    send(1, 8'h64, 1'b1, 1'b0, 24'h923C64);
    // Filtered message still advances state: running status continues.
    send(1, 8'h91, 1'b0, 1'b0, 24'h923C64);
    send(1, 8'h3C, 1'b0, 1'b0, 24'h923C64);
    send(1, 8'h00, 1'b0, 1'b0, 24'h923C64);
    send(1, 8'h3C, 1'b0, 1'b0, 24'h923C64);
    send(1, 8'h00, 1'b0, 1'b0, 24'h923C64);

    // Reset between status and data discards running status.
    send(1, 8'h92, 1'b0, 1'b0, 24'h923C64);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    check("ch2_reset_data", {8'h0, data_b}, 32'h0);
    check("ch2_reset_valid", {31'h0, mv_b}, 32'h0);
    send(1, 8'h3C, 1'b0, 1'b1, 24'h000000);
    send(1, 8'h64, 1'b0, 1'b1, 24'h000000);

    repeat (2) @(negedge clk);
    check("omni_queue_empty", q_a.size(), 32'h0);
    check("ch2_queue_empty", q_b.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/midi_msg_assembler.md
Name: midi_msg_assembler

Overview:
- Upstream neighbour of the Note On/Off filter stage.
- Consumes raw MIDI bytes from the UART receiver and rebuilds complete channel-voice messages, handling MIDI running status.
- Presents each message as a 24-bit word {status, data1, data2} plus a one-cycle valid strobe.
- Ignores System Exclusive, System Common and Real-Time traffic, and can optionally filter on one MIDI channel.

Parameters:
- OMNI, 1, 1 = accept all 16 channels; 0 = accept only CHANNEL.
- CHANNEL, 0, 4-bit channel number (0..15) accepted when OMNI=0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- byte_in  input  8  received UART byte; valid only when byte_valid=1.
- byte_valid  input  1  one-cycle strobe per received byte; back-to-back strobes are legal.
- MIDI_data_out  output  24  [23:16] status, [15:8] data1, [7:0] data2; holds its value between messages.
- msg_valid  output  1  one-cycle pulse when MIDI_data_out is updated.
- sync_err  output  1  one-cycle pulse when a data byte arrives with no running status, or a message is abandoned.

Behaviour:
- Reset, checked every cycle: MIDI_data_out=0, msg_valid=0, sync_err=0, running_status=0 (none), state=IDLE. Reset overrides a coincident byte_valid and discards any partial message.
- Byte classes:
  - status = bit7=1
  - data = bit7=0
  - real-time = 0xF8..0xFF
- Real-time bytes change nothing: state, running status, partial data and outputs are all unchanged. They may arrive in any state.
- Data-byte count per status: 0x8n, 0x9n, 0xAn, 0xBn, 0xEn need 2; 0xCn, 0xDn need 1.
- States: IDLE, WAIT_D1, WAIT_D2, SYSEX.
- Status 0x80..0xEF, any state:
  - latch running_status and go to WAIT_D1.
  - If the old state was WAIT_D2, or WAIT_D1 with a partial message pending, pulse sync_err.
- Status 0xF0: clear running_status, go to SYSEX.
- Status 0xF1..0xF7: clear running_status, go to IDLE. A 0xF7 ends SYSEX.
- SYSEX: data bytes are dropped silently. Any non-real-time status byte exits SYSEX and is then handled per the rules above.
- IDLE + data byte:
  - running_status valid: treat as data1 with that status and proceed as in WAIT_D1.
  - otherwise: drop the byte and pulse sync_err.
- WAIT_D1 + data byte:
  - store data1.
  - 1-byte message: emit with data2=0x00, next state WAIT_D1.
  - 2-byte message: go to WAIT_D2.
- WAIT_D2 + data byte: emit {running_status, data1, byte_in}, next state WAIT_D1. Running status stays valid, so the next data byte starts a new message.
- Emit:
  - On the clock edge that captures the final data byte, MIDI_data_out and msg_valid=1 become visible in the following cycle. Latency is 1 cycle from the final byte_valid.
  - If OMNI=0 and status[3:0]≠CHANNEL, the message is fully parsed (state advances) but MIDI_data_out and msg_valid are not updated.
- Note On with velocity 0 is passed unchanged; the downstream stage owns Note On/Off semantics.
- msg_valid and sync_err never assert for more than one consecutive cycle per triggering byte.

Decomposition:
- Shared package midi_pkg holds:
  - status-nibble constants: NOTE_OFF=4'h8, NOTE_ON=4'h9, POLY_AT=4'hA, CC=4'hB, PROG=4'hC, CHAN_AT=4'hD, PITCH=4'hE.
  - SYSEX_START=8'hF0, SYSEX_END=8'hF7, RT_MIN=8'hF8.
  - state encoding.
  - function data_len(status) returning 1 or 2.
- Single module; no sub-module needed. The byte classifier is a small combinational block inside it.

Test Plan:
- Bytes 0x90,0x3C,0x64 -> one msg_valid, MIDI_data_out=24'h903C64 one cycle after the 0x64 strobe.
- Running status 0x90,0x3C,0x64,0x40,0x00 -> two pulses: 24'h903C64, then 24'h904000.
- Program change 0xC5,0x07 -> 24'hC50700. Then 0x08 alone -> 24'hC50800 (running status on a 1-byte message).
- Real-time interleave 0x80,0xF8,0x3C,0xFE,0x00 -> single output 24'h803C00; state undisturbed.
- SysEx 0xF0,0x7E,0x01,0xF7 then 0x22 -> no msg_valid, sync_err pulses on 0x22 (running status cleared).
- OMNI=0, CHANNEL=2: 0x91,0x3C,0x64 -> no msg_valid. Then 0x92,0x3C,0x64 -> 24'h923C64. Asserting reset between 0x92 and 0x3C -> no output, and 0x3C afterwards raises sync_err.
